izh_burst_sequencer: RTL and testbench

Output-side companion of the Izhikevich neuron update logic: takes the 7-bit spike/burst descriptors the neuron emits, queues them, and plays each burst out as individual address-event spikes on a 4-phase req/ack output bus. Inter-spike intervals are timed in time-reference ticks. After the last spike of a burst, it returns a `burst_end` pulse tagged with the neuron index, so the controller can schedule the neuron's burst-end update.

---
 rtl/izh_aer_pkg.sv | 26 ++
 rtl/izh_burst_sequencer_if.sv | 23 ++
 rtl/izh_burst_fifo.sv | 47 ++++
 rtl/izh_burst_sequencer.sv | 98 +++++++++
 tb/tb_izh_burst_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/izh_aer_pkg.sv
// izh_aer_pkg: shared types and event-code field positions for the AER burst path.
package izh_aer_pkg;
  localparam int NEUR_W = 8;
  localparam int CODE_SPK = 6;
  localparam int CODE_SPK_REF_LSB = 3;
  localparam int CODE_ISI_LSB = 0;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_REL  = 3'd2,
    S_GAP  = 3'd3,
    S_END  = 3'd4
  } state_t;
  typedef struct packed {
    logic [NEUR_W-1:0] neur;
    logic [3:0]        n_spk;
    logic [2:0]        isi;
  } burst_desc_t;
  function automatic burst_desc_t decode(input logic [NEUR_W-1:0] neur, input logic [6:0] code);
    burst_desc_t d;
    d.neur  = neur;
    d.n_spk = {1'b0, code[CODE_SPK_REF_LSB +: 3]} + 4'd1;
    d.isi   = code[CODE_ISI_LSB +: 3];
    return d;
  endfunction
endpackage

// File: rtl/izh_burst_sequencer_if.sv
// izh_burst_sequencer_if: neuron-event input, AER output and status bundle.
interface izh_burst_sequencer_if #(parameter int N_ADDR = 8);
  logic              evt_valid;
  logic [N_ADDR-1:0] evt_neur;
  logic [6:0]        evt_code;
  logic              time_ref;
  logic              spk_req;
  logic              spk_ack;
  logic [N_ADDR-1:0] spk_addr;
  logic              burst_end;
  logic [N_ADDR-1:0] burst_end_neur;
  logic              fifo_full;
  logic              ovfl;
  logic              busy;
  modport master (
    output evt_valid, evt_neur, evt_code, time_ref, spk_ack,
    input  spk_req, spk_addr, burst_end, burst_end_neur, fifo_full, ovfl, busy
  );
  modport slave (
    input  evt_valid, evt_neur, evt_code, time_ref, spk_ack,
    output spk_req, spk_addr, burst_end, burst_end_neur, fifo_full, ovfl, busy
  );
endinterface

// File: rtl/izh_burst_fifo.sv
// izh_burst_fifo: synchronous queue of burst descriptors with wrap-bit pointers.
module izh_burst_fifo
  import izh_aer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        push,
  input  logic        pop,
  input  burst_desc_t din,
  output burst_desc_t dout,
  output logic        full,
  output logic        empty,
  output logic        empty_nxt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  burst_desc_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, cnt_d;
  logic do_push, do_pop, full_q, full_d;
  // a pop frees the head slot this edge, so a push into a full queue still fits
  always_comb begin
    do_pop = pop & (wr_q != rd_q);
    do_push = push & (!full_q | do_pop);
    wr_d = wr_q + PW'(do_push);
    rd_d = rd_q + PW'(do_pop);
    cnt_d = wr_d - rd_d;
    full_d = cnt_d == PW'(DEPTH);
  end
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      wr_q <= '0;
      rd_q <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      full_q <= full_d;
    end
  always_ff @(posedge CLK)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  assign dout = mem_q[rd_q[AW-1:0]];
  assign full = full_q;
  assign empty = wr_q == rd_q;
  assign empty_nxt = wr_d == rd_d;
endmodule

// File: rtl/izh_burst_sequencer.sv
// izh_burst_sequencer: queues neuron burst descriptors and plays them out as
// timed 4-phase AER spikes, reporting each completed burst.
module izh_burst_sequencer
  import izh_aer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int N_ADDR = NEUR_W
) (
  input logic                  CLK,
  input logic                  RSTN,
  izh_burst_sequencer_if.slave bus
);
  state_t state_q, state_d;
  logic [N_ADDR-1:0] addr_q, addr_d, end_neur_q, end_neur_d;
  logic [3:0] rem_q, rem_d;
  logic [2:0] isi_q, isi_d, gap_q, gap_d;
  logic req_q, req_d, end_q, end_d, ovfl_q, ovfl_d, busy_q, busy_d;
  logic push, pop, full, empty, empty_nxt;
  burst_desc_t head;
  izh_burst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK),
    .RSTN(RSTN),
    .push(push),
    .pop(pop),
    .din(decode(bus.evt_neur, bus.evt_code)),
    .dout(head),
    .full(full),
    .empty(empty),
    .empty_nxt(empty_nxt)
  );
  always_comb begin
    push = bus.evt_valid & bus.evt_code[CODE_SPK];
    pop = (state_q == S_IDLE) & !empty;
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    isi_d = isi_q;
    gap_d = gap_q;
    case (state_q)
      S_IDLE: if (!empty) begin
        state_d = S_REQ;
        addr_d = N_ADDR'(head.neur);
        rem_d = head.n_spk;
        isi_d = head.isi;
      end
      S_REQ: if (bus.spk_ack) begin
        state_d = S_REL;
        rem_d = rem_q - 4'd1;
      end
      S_REL: if (!bus.spk_ack) begin
        state_d = rem_q == 4'd0 ? S_END : (isi_q == 3'd0 ? S_REQ : S_GAP);
        gap_d = isi_q;
      end
      S_GAP: if (bus.time_ref) begin
        gap_d = gap_q - 3'd1;
        state_d = gap_q == 3'd1 ? S_REQ : S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
    // outputs follow the current state one edge later so every port is a flop
    req_d = state_q == S_REQ;
    end_d = state_q == S_END;
    end_neur_d = end_d ? addr_q : end_neur_q;
    ovfl_d = push & full & !pop;
    busy_d = (state_d != S_IDLE) | !empty_nxt;
  end
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      end_neur_q <= '0;
      rem_q <= '0;
      isi_q <= '0;
      gap_q <= '0;
      req_q <= 1'b0;
      end_q <= 1'b0;
      ovfl_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      end_neur_q <= end_neur_d;
      rem_q <= rem_d;
      isi_q <= isi_d;
      gap_q <= gap_d;
      req_q <= req_d;
      end_q <= end_d;
      ovfl_q <= ovfl_d;
      busy_q <= busy_d;
    end
  assign bus.spk_req = req_q;
  assign bus.spk_addr = addr_q;
  assign bus.burst_end = end_q;
  assign bus.burst_end_neur = end_neur_q;
  assign bus.fifo_full = full;
  assign bus.ovfl = ovfl_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_izh_burst_sequencer.sv
// tb_izh_burst_sequencer: directed and randomized bursts checked against a
// burst-level timing model with an AER responder driving ack and time_ref.
module tb_izh_burst_sequencer;
  typedef struct {
    logic [7:0] neur;
    int n;
    int isi;
    int t;
  } exp_t;
  localparam int BIG = 32'h7fff_ffff;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  exp_t cur;
  int cur_left, idle_ready, end_at, next_req, gap_left, gap_from, ack_rise, ack_cnt;
  int spikes = 0;
  int ends = 0;
  int ack_dly = 2;
  int tref_div = 1;
  int exp_rise;
  bit ack_hold = 0;
  bit req_prev, rise;
  izh_burst_sequencer_if #(.N_ADDR(8)) bus ();
  izh_burst_sequencer #(.FIFO_DEPTH(4), .N_ADDR(8)) dut (
    .CLK(clk),
    .RSTN(rstn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  // AER responder, tick source and burst-level reference model
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      cur_left = 0;
      idle_ready = 0;
      end_at = -1;
      next_req = -1;
      gap_left = 0;
      ack_cnt = 0;
      req_prev = 0;
      bus.spk_ack = 0;
      bus.time_ref = 0;
    end else begin
      exp_rise = cur_left > 0 ? next_req :
                 exp_q.size() > 0 ? ((idle_ready > exp_q[0].t + 3) ? idle_ready : exp_q[0].t + 3) : -1;
      rise = bus.spk_req && !req_prev;
      if (rise || cyc == exp_rise) begin
        chk("req_rise_cycle", rise ? cyc : 0, exp_rise);
        if (rise) begin
          if (cur_left == 0 && exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            cur_left = cur.n;
            idle_ready = BIG;
          end
          chk("req_addr", bus.spk_addr, cur.neur);
          next_req = -1;
          spikes++;
        end
      end
      if (!bus.spk_req && req_prev) chk("req_fall_cycle", cyc, ack_rise + 2);
      if (bus.spk_req && !bus.spk_ack && !ack_hold) begin
        if (ack_cnt == 0) begin
          bus.spk_ack = 1;
          ack_rise = cyc;
          if (cur_left > 0) cur_left--;
          chk("ack_addr", bus.spk_addr, cur.neur);
          ack_cnt = $urandom_range(0, ack_dly);
        end else ack_cnt--;
      end else if (!bus.spk_req && bus.spk_ack) begin
        if (ack_cnt == 0) begin
          bus.spk_ack = 0;
          ack_cnt = $urandom_range(0, ack_dly);
          if (cur_left == 0) begin
            end_at = cyc + 2;
            idle_ready = cyc + 4;
          end else if (cur.isi == 0) next_req = cyc + 2;
          else begin
            gap_left = cur.isi;
            gap_from = cyc + 1;
          end
        end else ack_cnt--;
      end
      bus.time_ref = $urandom_range(0, tref_div) == 0;
      if (bus.time_ref && gap_left > 0 && cyc >= gap_from) begin
        gap_left--;
        if (gap_left == 0) next_req = cyc + 2;
      end
      if (bus.burst_end || cyc == end_at) begin
        chk("burst_end_cycle", bus.burst_end ? cyc : 0, end_at);
        chk("burst_end_neur", bus.burst_end_neur, cur.neur);
        if (bus.burst_end) ends++;
        end_at = -1;
      end
      req_prev = bus.spk_req;
    end
  end
  task automatic drive(input logic [7:0] neur, input logic [6:0] code, input bit accept);
    bus.evt_valid = 1;
    bus.evt_neur = neur;
    bus.evt_code = code;
    if (accept && code[6])
      exp_q.push_back('{neur: neur, n: int'(code[5:3]) + 1, isi: int'(code[2:0]), t: cyc});
  endtask
  task automatic send(input logic [7:0] neur, input logic [6:0] code, input bit accept);
    drive(neur, code, accept);
    @(negedge clk);
    bus.evt_valid = 0;
  endtask
  task automatic wait_req(input string tag);
    int k = 0;
    while (!bus.spk_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(tag, bus.spk_req, 1);
  endtask
  task automatic wait_idle(input string tag);
    int k = 0;
    while ((bus.busy || exp_q.size() > 0 || cur_left > 0) && k < 6000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_drained"}, exp_q.size() + cur_left, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask
  initial begin
    int s0, e0, k, nev;
    logic [6:0] code;
    bus.evt_valid = 0;
    bus.evt_neur = 0;
    bus.evt_code = 0;
    bus.spk_ack = 0;
    bus.time_ref = 0;
    repeat (3) @(negedge clk);
    chk("rst_spk_req", bus.spk_req, 0);
    chk("rst_spk_addr", bus.spk_addr, 0);
    chk("rst_burst_end", bus.burst_end, 0);
    chk("rst_burst_end_neur", bus.burst_end_neur, 0);
    chk("rst_ovfl", bus.ovfl, 0);
    chk("rst_fifo_full", bus.fifo_full, 0);
    chk("rst_busy", bus.busy, 0);
    rstn = 1;
    repeat (2) @(negedge clk);
    // single spike, req two cycles after the strobe
    s0 = spikes; e0 = ends;
    send(8'd5, 7'b100_0000, 1);
    chk("single_busy", bus.busy, 1);
    chk("single_req_e1", bus.spk_req, 0);
    @(negedge clk);
    chk("single_req_e2", bus.spk_req, 0);
    @(negedge clk);
    chk("single_req_e3", bus.spk_req, 1);
    chk("single_addr", bus.spk_addr, 5);
    wait_idle("single");
    chk("single_spikes", spikes - s0, 1);
    chk("single_ends", ends - e0, 1);
    // four spikes separated by two ticks
    s0 = spikes; e0 = ends;
    send(8'd9, 7'b1_011_010, 1);
    wait_idle("burst");
    chk("burst_spikes", spikes - s0, 4);
    chk("burst_ends", ends - e0, 1);
    // back-to-back spikes plus a non-spike code
    s0 = spikes; e0 = ends;
    send(8'd3, 7'b1_010_000, 1);
    send(8'd7, 7'b0_111_111, 1);
    wait_idle("b2b");
    chk("b2b_spikes", spikes - s0, 3);
    chk("b2b_ends", ends - e0, 1);
    send(8'd7, 7'b0_111_111, 1);
    chk("nospk_busy", bus.busy, 0);
    // overflow while the first burst is stalled on ack
    s0 = spikes;
    ack_hold = 1;
    send(8'd1, 7'b1_000_000, 1);
    wait_req("ovf_first_req");
    for (int i = 0; i < 5; i++) begin
      drive(8'd10 + 8'(i), 7'b1_000_000, i < 4);
      @(negedge clk);
      if (i == 3) chk("ovf_full", bus.fifo_full, 1);
      if (i < 4) chk("ovf_early", bus.ovfl, 0);
    end
    bus.evt_valid = 0;
    chk("ovf_pulse", bus.ovfl, 1);
    @(negedge clk);
    chk("ovf_pulse_end", bus.ovfl, 0);
    chk("ovf_still_full", bus.fifo_full, 1);
    // push coinciding with the pop of a full queue
    ack_hold = 0;
    k = 0;
    while (!bus.burst_end && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("pp_end_seen", bus.burst_end, 1);
    send(8'd30, 7'b1_000_000, 1);
    chk("pp_no_ovfl", bus.ovfl, 0);
    chk("pp_full", bus.fifo_full, 1);
    wait_idle("ovf");
    chk("ovf_spikes", spikes - s0, 6);
    // reset in the middle of a handshake with two queued bursts
    e0 = ends;
    ack_hold = 1;
    send(8'd20, 7'b1_001_000, 1);
    send(8'd21, 7'b1_000_000, 1);
    send(8'd22, 7'b1_000_000, 1);
    wait_req("rst_req_up");
    #2 rstn = 0;
    #1 chk("rst_req_drop", bus.spk_req, 0);
    chk("rst_mid_full", bus.fifo_full, 0);
    repeat (2) @(negedge clk);
    rstn = 1;
    ack_hold = 0;
    repeat (10) @(negedge clk);
    chk("rst_after_busy", bus.busy, 0);
    chk("rst_no_end", ends - e0, 0);
    // randomized bursts, never more than the queue holds
    for (int r = 0; r < 25; r++) begin
      ack_dly = $urandom_range(0, 3);
      tref_div = $urandom_range(0, 3);
      nev = $urandom_range(1, 3);
      for (int j = 0; j < nev; j++) begin
        code = 7'($urandom);
        if ($urandom_range(0, 4) != 0) code[6] = 1'b1;
        send(8'($urandom), code, 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
